uart_wb_tx: RTL and testbench
=============================

UART_WB_TX -- requirements
Module: uart_wb_tx

Interface
REQ-001 Parameter CLK_DIV, default 139: wb_clk cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16: transmit FIFO entries; power of two, 2..256.
REQ-003 wb_clk  input  1  single clock for all logic.
REQ-004 wb_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_wb_adr  input  1  register select: 0 = DATA, 1 = STATUS.
REQ-006 i_wb_dat  input  32  write data; only bits [7:0] are used.
REQ-007 i_wb_we  input  1  1 = write, 0 = read.
REQ-008 i_wb_cyc  input  1  bus request, held high until o_wb_ack.
REQ-009 o_wb_rdt  output  32  read data.
REQ-010 o_wb_ack  output  1  single-cycle transfer acknowledge.
REQ-011 o_tx  output  1  serial line, 8N1, idle high; drives the board TX pin.

Function
REQ-012 The block SHALL assert o_wb_ack for exactly one cycle, on the edge after it samples i_wb_cyc high with o_wb_ack low.
REQ-013 The block SHALL drive o_wb_ack low on the edge after an ack, so that a held i_wb_cyc never produces back-to-back acks.
REQ-014 Write to DATA, FIFO not full: the block SHALL push i_wb_dat[7:0] on the ack edge.
REQ-015 Write to DATA, FIFO full: the block SHALL drop the byte and set the sticky overflow bit; the write is still acked.
REQ-016 Write to STATUS SHALL be acked and otherwise ignored.
REQ-017 Read of STATUS SHALL return: bit0 = idle (FIFO empty and FSM IDLE); bit1 = FIFO full; bit2 = overflow; bits[15:8] = FIFO level; all other bits 0.
REQ-018 Read of DATA SHALL return 0.
REQ-019 A STATUS read SHALL clear overflow on its ack edge; an overflow event in the same cycle sets it, and set wins.
REQ-020 o_wb_rdt SHALL be valid while o_wb_ack is high and SHALL be 0 otherwise.
REQ-021 The FSM SHALL have the states IDLE, START, DATA, STOP, and a 16-bit baud counter that reloads to CLK_DIV-1 on every state or bit change.
REQ-022 IDLE: o_tx = 1; when the FIFO is non-empty the FSM SHALL pop one byte into the shift register and enter START on the next edge.
REQ-023 START: o_tx = 0 for CLK_DIV cycles, then DATA.
REQ-024 DATA: 8 bits, LSB first, each held CLK_DIV cycles; after bit 7 the FSM enters STOP.
REQ-025 STOP: o_tx = 1 for CLK_DIV cycles.
REQ-026 At the end of STOP the FSM SHALL enter START with a pop if the FIFO is non-empty, otherwise IDLE.
REQ-027 Back-to-back frames SHALL therefore be exactly 10*CLK_DIV cycles apart, with no idle gap.
REQ-028 A simultaneous push and pop SHALL leave the level unchanged; this holds when full and when empty.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the level SHALL be held at log2(FIFO_DEPTH)+1 bits.
REQ-030 Latency: a write acked at edge N to an empty, idle block SHALL pop at edge N+1 and drive o_tx low from edge N+1.
REQ-031 o_tx SHALL be registered and glitch-free.

Reset
REQ-032 While wb_rst is high, regardless of clock: o_tx = 1, o_wb_ack = 0, o_wb_rdt = 0, FSM = IDLE, FIFO empty, overflow = 0, baud counter = CLK_DIV-1.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with o_tx = 1, and SHALL discard all queued bytes.
REQ-034 The first transfer after wb_rst deasserts SHALL be acked normally; no warm-up cycles are required.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-035 Write 0x55 to DATA after reset -> o_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; STATUS reads 0x01 afterwards.
REQ-036 Five writes 0x01..0x05 issued while the first frame is still in START -> all five are accepted (one is already popped), frames are contiguous at 40-cycle spacing, and STATUS bit1 is set after the fifth write.
REQ-037 Six rapid writes with the FSM busy -> the sixth is dropped; STATUS reads overflow=1, then a second STATUS read shows overflow=0.
REQ-038 A held i_wb_cyc read of STATUS -> exactly one ack cycle; o_wb_rdt is 0 outside the ack.
REQ-039 Assert wb_rst during DATA bit 3 of 0xA5 with two bytes queued -> o_tx = 1 immediately and STATUS reads 0x01 after release; no further frames are sent.
REQ-040 Write landing in the same cycle as a pop with the FIFO full -> accepted, level stays 4, and no overflow.

Source files
------------

// File: rtl/uart_wb_tx.sv
// uart_wb_tx: Wishbone-attached 8N1 UART transmitter with a power-of-two
// transmit FIFO and a 16-bit down-counting baud timer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (line low) for CLK_DIV cycles
// DATA   | 8 data bits, LSB first, CLK_DIV cycles each
// STOP   | stop bit (line high); chains straight into START if FIFO non-empty
module uart_wb_tx #(
    parameter int CLK_DIV    = 139,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam int          LVL_W       = AW + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FSM / serializer state
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        pop;

    // FIFO state
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifo_empty, fifo_full;
    logic [7:0]       fifo_rd_data;
    logic             push;

    // Bus state
    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;
    logic        ovf_q, ovf_d;
    logic        bus_req, wr_data, rd_status, ovf_set;
    logic [31:0] status;

    // Only the low byte of write data is meaningful.
    logic unused_dat;
    assign unused_dat = ^i_wb_dat[31:8];

    assign fifo_empty   = (level_q == '0);
    assign fifo_full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_rd_data = mem_q[rd_ptr_q];

    // A request is serviced on the edge after it is seen with ack low,
    // so a held cyc can never produce two consecutive ack cycles.
    assign bus_req   = i_wb_cyc & ~ack_q;
    assign wr_data   = bus_req & i_wb_we & ~i_wb_adr;
    assign rd_status = bus_req & ~i_wb_we & i_wb_adr;

    // A pop in the same cycle frees a slot, so a write to a full FIFO is
    // still accepted when the FSM is taking a byte out.
    assign push    = wr_data & (~fifo_full | pop);
    assign ovf_set = wr_data & fifo_full & ~pop;

    // FSM state register
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= BAUD_RELOAD;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // FSM next-state: baud timer counts down and reloads on every state or bit change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = BAUD_RELOAD;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = BAUD_RELOAD;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    cnt_d = BAUD_RELOAD;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = BAUD_RELOAD;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM output: line level is registered from the next state so it changes
    // on the same edge as the state and never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Status word; with a 256-deep FIFO the level field wraps to 0 when full,
    // the full bit tells the two cases apart.
    always_comb begin
        status       = '0;
        status[0]    = fifo_empty & (state_q == S_IDLE);
        status[1]    = fifo_full;
        status[2]    = ovf_q;
        status[15:8] = 8'(level_q);
    end

    // Bus and FIFO bookkeeping next values; overflow set wins over read-clear
    always_comb begin
        ack_d    = bus_req;
        rdt_d    = rd_status ? status : '0;
        ovf_d    = ovf_set ? 1'b1 : (rd_status ? 1'b0 : ovf_q);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Bus and FIFO pointer registers
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ack_q    <= 1'b0;
            rdt_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge wb_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wb_dat[7:0];
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_tx     = tx_q;

endmodule

// File: tb/tb_uart_wb_tx.sv
// Directed testbench for uart_wb_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_wb_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;

    logic        wb_clk   = 1'b0;
    logic        wb_rst   = 1'b0;
    logic        i_wb_adr = 1'b0;
    logic [31:0] i_wb_dat = '0;
    logic        i_wb_we  = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_tx;

    int tests = 0;
    int fails = 0;

    uart_wb_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .o_tx     (o_tx)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Bus write; returns 1 ns after the ack edge.
    task automatic wb_write(input logic adr, input logic [7:0] dat);
        int n;
        @(negedge wb_clk);
        i_wb_adr = adr;
        i_wb_we  = 1'b1;
        i_wb_dat = {24'hABCDEF, dat};
        i_wb_cyc = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk);
            #1;
            n++;
        end while (!o_wb_ack && n < 8);
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        if (!o_wb_ack) begin
            tests++;
            fails++;
            $display("FAIL wb_write_timeout: ack=%b required 1", o_wb_ack);
        end
    endtask

    // Bus read; data captured while ack is high.
    task automatic wb_read(input logic adr, output logic [31:0] dat);
        int n;
        @(negedge wb_clk);
        i_wb_adr = adr;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk);
            #1;
            n++;
        end while (!o_wb_ack && n < 8);
        dat = o_wb_rdt;
        i_wb_cyc = 1'b0;
        if (!o_wb_ack) begin
            tests++;
            fails++;
            $display("FAIL wb_read_timeout: ack=%b required 1", o_wb_ack);
        end
    endtask

    // Checks 40 consecutive line samples, starting at the next edge.
    task automatic check_frame(input logic [7:0] b, input string name);
        logic [9:0] exp_f;
        logic [9:0] got_f;
        int bad;
        exp_f = {1'b1, b, 1'b0};
        got_f = '0;
        bad = 0;
        for (int k = 0; k < 10 * CLK_DIV; k++) begin
            @(posedge wb_clk);
            #1;
            if (o_tx !== exp_f[k / CLK_DIV]) bad++;
            if ((k % CLK_DIV) == 1) got_f[k / CLK_DIV] = o_tx;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: line bits %b required %b (%0d bad samples)", name, got_f, exp_f, bad);
        end
    endtask

    task automatic check_status(input logic [31:0] exp_v, input string name);
        logic [31:0] v;
        wb_read(1'b1, v);
        tests++;
        if (v !== exp_v) begin
            fails++;
            $display("FAIL %s: status 0x%08h required 0x%08h", name, v, exp_v);
        end
    endtask

    task automatic check_line_idle(input int cycles, input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge wb_clk);
            #1;
            if (o_tx !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d cycles with tx low, required 0", name, bad);
        end
    endtask

    task automatic test_reset();
        int bad;
        #2 wb_rst = 1'b1;
        #1;
        tests++;
        if (o_tx !== 1'b1) begin
            fails++;
            $display("FAIL reset_tx: tx=%b required 1", o_tx);
        end
        tests++;
        if (o_wb_ack !== 1'b0) begin
            fails++;
            $display("FAIL reset_ack: ack=%b required 0", o_wb_ack);
        end
        tests++;
        if (o_wb_rdt !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdt: rdt=0x%08h required 0", o_wb_rdt);
        end
        i_wb_cyc = 1'b1;
        i_wb_adr = 1'b1;
        i_wb_we  = 1'b0;
        bad = 0;
        repeat (3) begin
            @(posedge wb_clk);
            #1;
            if (o_wb_ack !== 1'b0 || o_tx !== 1'b1) bad++;
        end
        i_wb_cyc = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_held: %0d cycles with ack or tx wrong, required 0", bad);
        end
        @(negedge wb_clk);
        wb_rst = 1'b0;
        check_status(32'h0000_0001, "reset_status");
    endtask

    task automatic test_regs();
        logic [31:0] v;
        wb_write(1'b1, 8'hFF);
        check_line_idle(6, "status_write_no_frame");
        check_status(32'h0000_0001, "status_write_ignored");
        wb_read(1'b0, v);
        tests++;
        if (v !== 32'h0) begin
            fails++;
            $display("FAIL data_read: rdt=0x%08h required 0", v);
        end
    endtask

    task automatic test_single_frame();
        wb_write(1'b0, 8'h55);
        check_frame(8'h55, "frame_55");
        repeat (2) @(posedge wb_clk);
        check_status(32'h0000_0001, "single_status_idle");
    endtask

    task automatic test_held_cyc();
        int acks;
        int bad;
        logic [31:0] at_ack;
        acks = 0;
        bad = 0;
        at_ack = '0;
        @(negedge wb_clk);
        i_wb_cyc = 1'b1;
        i_wb_we  = 1'b0;
        i_wb_adr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge wb_clk);
            #1;
            if (k == 1) i_wb_cyc = 1'b0;
            if (o_wb_ack) begin
                acks++;
                at_ack = o_wb_rdt;
            end else if (o_wb_rdt !== 32'h0) begin
                bad++;
            end
        end
        tests++;
        if (acks != 1) begin
            fails++;
            $display("FAIL held_cyc_acks: %0d acks required 1", acks);
        end
        tests++;
        if (at_ack !== 32'h0000_0001) begin
            fails++;
            $display("FAIL held_cyc_rdt: rdt=0x%08h required 0x00000001", at_ack);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL held_cyc_rdt_zero: %0d non-zero rdt cycles without ack, required 0", bad);
        end
    endtask

    task automatic test_fifo_full_b2b();
        wb_write(1'b0, 8'h01);
        fork
            begin
                for (int i = 2; i <= 5; i++) wb_write(1'b0, 8'(i));
                check_status(32'h0000_0402, "b2b_full_status");
            end
            begin
                for (int i = 1; i <= 5; i++) check_frame(8'(i), "b2b_frame");
            end
        join
        repeat (2) @(posedge wb_clk);
        check_status(32'h0000_0001, "b2b_drained");
    endtask

    task automatic test_overflow();
        wb_write(1'b0, 8'h11);
        fork
            begin
                for (int i = 2; i <= 6; i++) wb_write(1'b0, 8'h10 + 8'(i));
                check_status(32'h0000_0406, "ovf_set");
                check_status(32'h0000_0402, "ovf_cleared");
            end
            begin
                for (int i = 1; i <= 5; i++) check_frame(8'h10 + 8'(i), "ovf_frame");
            end
        join
        repeat (2) @(posedge wb_clk);
        check_status(32'h0000_0001, "ovf_drained");
        check_line_idle(45, "ovf_dropped_not_sent");
    endtask

    task automatic test_push_pop_full();
        wb_write(1'b0, 8'h21);
        fork
            begin
                for (int i = 2; i <= 5; i++) wb_write(1'b0, 8'h20 + 8'(i));
                repeat (32) @(posedge wb_clk);
                #1;
                wb_write(1'b0, 8'h26);
                check_status(32'h0000_0402, "pushpop_full_level");
            end
            begin
                for (int i = 1; i <= 6; i++) check_frame(8'h20 + 8'(i), "pushpop_frame");
            end
        join
        repeat (2) @(posedge wb_clk);
        check_status(32'h0000_0001, "pushpop_drained");
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        wb_write(1'b0, 8'hA5);
        wb_write(1'b0, 8'hB1);
        wb_write(1'b0, 8'hB2);
        repeat (14) @(posedge wb_clk);
        #1;
        tests++;
        if (o_tx !== 1'b0) begin
            fails++;
            $display("FAIL midframe_bit3: tx=%b required 0", o_tx);
        end
        wb_rst = 1'b1;
        #1;
        tests++;
        if (o_tx !== 1'b1) begin
            fails++;
            $display("FAIL midframe_abort: tx=%b required 1", o_tx);
        end
        bad = 0;
        repeat (2) begin
            @(posedge wb_clk);
            #1;
            if (o_tx !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midframe_hold: %0d cycles tx low in reset, required 0", bad);
        end
        @(negedge wb_clk);
        wb_rst = 1'b0;
        check_status(32'h0000_0001, "midframe_status");
        check_line_idle(60, "midframe_no_frames");
    endtask

    initial begin
        test_reset();
        test_regs();
        test_single_frame();
        test_held_cyc();
        test_fifo_full_b2b();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
